// File: rtl/trdb_reg_mc.sv
// Trace debugger register file: control/status, range comparators and a software dump FIFO.
// Optional build macro TRDB_STICKY_STATUS_EN makes the overflow STATUS bits sticky (W1C).
module trdb_reg_mc #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned NUM_RANGES     = 4,
  parameter int unsigned SW_FIFO_DEPTH  = 4,
  parameter int unsigned XLEN           = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       per_valid_i,
  input  logic                       per_we_i,
  input  logic [APB_ADDR_WIDTH-1:0]  per_addr_i,
  input  logic [31:0]                per_wdata_i,
  output logic                       per_ready_o,
  output logic [31:0]                per_rdata_o,
  output logic                       trace_enable_o,
  output logic                       trace_activated_o,
  output logic                       trace_full_addr_o,
  output logic                       trace_implicit_ret_o,
  output logic                       clear_fifo_o,
  output logic                       flush_stream_o,
  input  logic                       flush_confirm_i,
  input  logic                       trace_req_deactivate_i,
  output logic [NUM_RANGES-1:0]      range_en_o,
  output logic [NUM_RANGES*XLEN-1:0] lower_addr_o,
  output logic [NUM_RANGES*XLEN-1:0] higher_addr_o,
  input  logic                       trace_qualified_i,
  input  logic                       trace_priv_match_i,
  input  logic                       trace_fifo_overflow_i,
  input  logic                       external_fifo_overflow_i,
  input  logic [NUM_RANGES-1:0]      range_match_i,
  output logic [31:0]                sw_word_o,
  output logic                       sw_valid_o,
  input  logic                       sw_grant_i,
  output logic                       tu_req_o
);

  localparam int unsigned PtrW = $clog2(SW_FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [APB_ADDR_WIDTH-1:0] addr_t;
  localparam addr_t AddrCtrl    = addr_t'(32'h00);
  localparam addr_t AddrStatus  = addr_t'(32'h04);
  localparam addr_t AddrRangeEn = addr_t'(32'h08);
  localparam addr_t AddrDump    = addr_t'(32'h0C);
  localparam addr_t AddrDumpT   = addr_t'(32'h10);
  localparam addr_t AddrSwfifo  = addr_t'(32'h14);

  function automatic addr_t range_addr(input int unsigned idx, input logic hi);
    return addr_t'(32'h20 + 8 * idx + (hi ? 32'd4 : 32'd0));
  endfunction

  logic enable_q, activated_q, clear_q, flush_q, full_addr_q, impl_ret_q;
  logic [NUM_RANGES-1:0] range_en_q;
  logic [XLEN-1:0]       lower_q  [NUM_RANGES];
  logic [XLEN-1:0]       higher_q [NUM_RANGES];

  logic [31:0]     fifo_q [SW_FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;

  logic qual_q, priv_q, ovf_q, ext_ovf_q, ovf_d, ext_ovf_d;
  logic [NUM_RANGES-1:0] rm_q;

  logic wr_en, ctrl_we, dump_req, fifo_full, fifo_empty, pop, stall, push;

  always_comb begin
    wr_en      = per_valid_i & per_we_i;
    ctrl_we    = wr_en & (per_addr_i == AddrCtrl);
    dump_req   = wr_en & ((per_addr_i == AddrDump) | (per_addr_i == AddrDumpT));
    fifo_full  = (cnt_q == CntW'(SW_FIFO_DEPTH));
    fifo_empty = (cnt_q == '0);
    pop        = ~fifo_empty & sw_grant_i;
    // A pop in the same cycle frees the slot, so a full FIFO only stalls without a grant.
    stall      = dump_req & enable_q & fifo_full & ~pop;
    push       = dump_req & enable_q & ~stall;
  end

  assign per_ready_o = ~stall;
  assign tu_req_o    = push & (per_addr_i == AddrDumpT);
  assign sw_valid_o  = ~fifo_empty;
  assign sw_word_o   = fifo_q[rd_ptr_q];

`ifdef TRDB_STICKY_STATUS_EN
  logic status_we;
  assign status_we = wr_en & (per_addr_i == AddrStatus);
  assign ovf_d     = trace_fifo_overflow_i | (ovf_q & ~(status_we & per_wdata_i[3]));
  assign ext_ovf_d = external_fifo_overflow_i | (ext_ovf_q & ~(status_we & per_wdata_i[4]));
`else
  assign ovf_d     = trace_fifo_overflow_i;
  assign ext_ovf_d = external_fifo_overflow_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable_q    <= 1'b0;
      activated_q <= 1'b0;
      clear_q     <= 1'b0;
      flush_q     <= 1'b0;
      full_addr_q <= 1'b0;
      impl_ret_q  <= 1'b0;
      range_en_q  <= '0;
      for (int i = 0; i < NUM_RANGES; i++) begin
        lower_q[i]  <= '0;
        higher_q[i] <= '0;
      end
      qual_q    <= 1'b0;
      priv_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ext_ovf_q <= 1'b0;
      rm_q      <= '0;
    end else begin
      clear_q <= ctrl_we & per_wdata_i[2];
      if (ctrl_we) begin
        enable_q    <= per_wdata_i[0];
        full_addr_q <= per_wdata_i[4];
        impl_ret_q  <= per_wdata_i[5];
      end
      // Handshakes override only their own bit of a concurrent CTRL write.
      if (trace_req_deactivate_i) activated_q <= 1'b0;
      else if (ctrl_we)           activated_q <= per_wdata_i[1];
      if (flush_confirm_i)        flush_q     <= 1'b0;
      else if (ctrl_we)           flush_q     <= per_wdata_i[3];
      if (wr_en && per_addr_i == AddrRangeEn) range_en_q <= per_wdata_i[NUM_RANGES-1:0];
      for (int i = 0; i < NUM_RANGES; i++) begin
        if (wr_en && per_addr_i == range_addr(i, 1'b0)) lower_q[i]  <= XLEN'(per_wdata_i);
        if (wr_en && per_addr_i == range_addr(i, 1'b1)) higher_q[i] <= XLEN'(per_wdata_i);
      end
      qual_q    <= trace_qualified_i;
      priv_q    <= trace_priv_match_i;
      ovf_q     <= ovf_d;
      ext_ovf_q <= ext_ovf_d;
      rm_q      <= range_match_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < SW_FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (clear_q) begin
      // Clearing empties the FIFO; a push in the same cycle lands in the emptied FIFO.
      rd_ptr_q <= '0;
      wr_ptr_q <= PtrW'(push);
      cnt_q    <= CntW'(push);
      if (push) fifo_q[0] <= per_wdata_i;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= per_wdata_i;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  always_comb begin
    lower_addr_o  = '0;
    higher_addr_o = '0;
    for (int i = 0; i < NUM_RANGES; i++) begin
      lower_addr_o[i*XLEN +: XLEN]  = lower_q[i];
      higher_addr_o[i*XLEN +: XLEN] = higher_q[i];
    end
  end

  assign trace_enable_o       = enable_q;
  assign trace_activated_o    = activated_q;
  assign trace_full_addr_o    = full_addr_q;
  assign trace_implicit_ret_o = impl_ret_q;
  assign clear_fifo_o         = clear_q;
  assign flush_stream_o       = flush_q;
  assign range_en_o           = range_en_q;

  always_comb begin
    per_rdata_o = '0;
    case (per_addr_i)
      AddrCtrl: per_rdata_o[5:0] = {impl_ret_q, full_addr_q, flush_q, clear_q, activated_q,
                                    enable_q};
      AddrStatus: begin
        per_rdata_o[4:0]             = {ext_ovf_q, ovf_q, |rm_q, priv_q, qual_q};
        per_rdata_o[8+:NUM_RANGES]   = rm_q;
      end
      AddrRangeEn: per_rdata_o[NUM_RANGES-1:0] = range_en_q;
      AddrSwfifo: begin
        per_rdata_o[4:0] = 5'(cnt_q);
        per_rdata_o[8]   = fifo_full;
        per_rdata_o[9]   = fifo_empty;
      end
      default: ;
    endcase
    for (int i = 0; i < NUM_RANGES; i++) begin
      if (per_addr_i == range_addr(i, 1'b0)) per_rdata_o = 32'(lower_q[i]);
      if (per_addr_i == range_addr(i, 1'b1)) per_rdata_o = 32'(higher_q[i]);
    end
  end

endmodule

// File: tb/tb_trdb_reg_mc.sv
// Directed self-checking bench for trdb_reg_mc; honours TRDB_STICKY_STATUS_EN if defined.
module tb_trdb_reg_mc;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        per_valid_i = 1'b0, per_we_i = 1'b0;
  logic [11:0] per_addr_i = '0;
  logic [31:0] per_wdata_i = '0;
  logic        per_ready_o;
  logic [31:0] per_rdata_o;
  logic        trace_enable_o, trace_activated_o, trace_full_addr_o, trace_implicit_ret_o;
  logic        clear_fifo_o, flush_stream_o;
  logic        flush_confirm_i = 1'b0, trace_req_deactivate_i = 1'b0;
  logic [3:0]  range_en_o;
  logic [127:0] lower_addr_o, higher_addr_o;
  logic        trace_qualified_i = 1'b0, trace_priv_match_i = 1'b0;
  logic        trace_fifo_overflow_i = 1'b0, external_fifo_overflow_i = 1'b0;
  logic [3:0]  range_match_i = '0;
  logic [31:0] sw_word_o;
  logic        sw_valid_o, sw_grant_i = 1'b0, tu_req_o;

  int n_vec = 0;
  int n_err = 0;

  trdb_reg_mc dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .per_valid_i(per_valid_i), .per_we_i(per_we_i), .per_addr_i(per_addr_i),
    .per_wdata_i(per_wdata_i), .per_ready_o(per_ready_o), .per_rdata_o(per_rdata_o),
    .trace_enable_o(trace_enable_o), .trace_activated_o(trace_activated_o),
    .trace_full_addr_o(trace_full_addr_o), .trace_implicit_ret_o(trace_implicit_ret_o),
    .clear_fifo_o(clear_fifo_o), .flush_stream_o(flush_stream_o),
    .flush_confirm_i(flush_confirm_i), .trace_req_deactivate_i(trace_req_deactivate_i),
    .range_en_o(range_en_o), .lower_addr_o(lower_addr_o), .higher_addr_o(higher_addr_o),
    .trace_qualified_i(trace_qualified_i), .trace_priv_match_i(trace_priv_match_i),
    .trace_fifo_overflow_i(trace_fifo_overflow_i),
    .external_fifo_overflow_i(external_fifo_overflow_i), .range_match_i(range_match_i),
    .sw_word_o(sw_word_o), .sw_valid_o(sw_valid_o), .sw_grant_i(sw_grant_i),
    .tu_req_o(tu_req_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    per_valid_i = 1'b1; per_we_i = 1'b1; per_addr_i = a; per_wdata_i = d;
    tick();
    per_valid_i = 1'b0; per_we_i = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    per_valid_i = 1'b1; per_we_i = 1'b0; per_addr_i = a;
    #1;
    chk(tag, per_rdata_o, exp);
    per_valid_i = 1'b0;
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_ready", 32'(per_ready_o), 32'd1);
    chk("rst_sw_valid", 32'(sw_valid_o), 32'd0);
    chk("rst_tu_req", 32'(tu_req_o), 32'd0);
    chk("rst_enable", 32'(trace_enable_o), 32'd0);
    rd("rst_ctrl", 12'h000, 32'h0);
    rd("rst_swfifo", 12'h014, 32'h200);
    #3 rst_ni = 1'b1;
    tick();

    // CTRL = 0x3F
    wr(12'h000, 32'h3F);
    chk("ctrl_en", 32'(trace_enable_o), 32'd1);
    chk("ctrl_act", 32'(trace_activated_o), 32'd1);
    chk("ctrl_full", 32'(trace_full_addr_o), 32'd1);
    chk("ctrl_iret", 32'(trace_implicit_ret_o), 32'd1);
    chk("ctrl_flush", 32'(flush_stream_o), 32'd1);
    chk("ctrl_clear_hi", 32'(clear_fifo_o), 32'd1);
    tick();
    chk("ctrl_clear_lo", 32'(clear_fifo_o), 32'd0);
    rd("ctrl_3b", 12'h000, 32'h3B);
    tick();

    // Handshakes clear flush and activated
    flush_confirm_i = 1'b1; trace_req_deactivate_i = 1'b1;
    tick();
    flush_confirm_i = 1'b0; trace_req_deactivate_i = 1'b0;
    rd("ctrl_after_hs", 12'h000, 32'h31);
    tick();

    // Flush write collides with flush_confirm
    flush_confirm_i = 1'b1;
    wr(12'h000, 32'h0B);
    flush_confirm_i = 1'b0;
    chk("flush_wins", 32'(flush_stream_o), 32'd0);
    chk("flush_act_applied", 32'(trace_activated_o), 32'd1);
    chk("flush_full_applied", 32'(trace_full_addr_o), 32'd0);
    rd("ctrl_03", 12'h000, 32'h03);
    tick();

    // FIFO fill, stall, release
    rd("fifo_empty", 12'h014, 32'h200);
    tick();
    wr(12'h00C, 32'hA0);
    chk("dump_valid", 32'(sw_valid_o), 32'd1);
    chk("dump_word", sw_word_o, 32'hA0);
    wr(12'h00C, 32'hA1);
    wr(12'h00C, 32'hA2);
    wr(12'h00C, 32'hA3);
    rd("fifo_full", 12'h014, 32'h104);
    per_valid_i = 1'b1; per_we_i = 1'b1; per_addr_i = 12'h00C; per_wdata_i = 32'hA4;
    #1;
    chk("stall_0", 32'(per_ready_o), 32'd0);
    tick();
    chk("stall_1", 32'(per_ready_o), 32'd0);
    sw_grant_i = 1'b1;
    #1;
    chk("stall_release", 32'(per_ready_o), 32'd1);
    chk("pop_a0", sw_word_o, 32'hA0);
    tick();
    sw_grant_i = 1'b0; per_valid_i = 1'b0; per_we_i = 1'b0;
    rd("fifo_4_after", 12'h014, 32'h104);
    tick();
    for (int k = 1; k <= 4; k++) begin
      sw_grant_i = 1'b1;
      #1;
      chk($sformatf("drain_%0d", k), sw_word_o, 32'hA0 + 32'(k));
      tick();
    end
    sw_grant_i = 1'b0;
    chk("drained", 32'(sw_valid_o), 32'd0);

    // DUMP_WITH_TIME
    per_valid_i = 1'b1; per_we_i = 1'b1; per_addr_i = 12'h010; per_wdata_i = 32'hCAFE;
    #1;
    chk("tu_req_hi", 32'(tu_req_o), 32'd1);
    tick();
    per_valid_i = 1'b0; per_we_i = 1'b0;
    #1;
    chk("tu_req_lo", 32'(tu_req_o), 32'd0);
    chk("cafe_word", sw_word_o, 32'hCAFE);
    sw_grant_i = 1'b1;
    tick();
    sw_grant_i = 1'b0;

    // Range registers
    wr(12'h030, 32'h1000);
    wr(12'h034, 32'h1FFF);
    wr(12'h008, 32'h4);
    chk("lower2", lower_addr_o[64 +: 32], 32'h1000);
    chk("higher2", higher_addr_o[64 +: 32], 32'h1FFF);
    chk("range_en", 32'(range_en_o), 32'h4);
    rd("rd_higher2", 12'h034, 32'h1FFF);
    tick();

    // Dumps discarded while disabled
    wr(12'h000, 32'h0);
    per_valid_i = 1'b1; per_we_i = 1'b1; per_addr_i = 12'h00C; per_wdata_i = 32'h55;
    #1;
    chk("dis_ready", 32'(per_ready_o), 32'd1);
    tick();
    per_valid_i = 1'b0; per_we_i = 1'b0;
    chk("dis_discard", 32'(sw_valid_o), 32'd0);

    // STATUS sampled one cycle late
    trace_qualified_i = 1'b1; range_match_i = 4'b0010;
    rd("status_late", 12'h004, 32'h0);
    tick();
    rd("status_205", 12'h004, 32'h205);
    trace_qualified_i = 1'b0; range_match_i = 4'b0000;
    tick();
    trace_fifo_overflow_i = 1'b1;
    tick();
    trace_fifo_overflow_i = 1'b0;
    rd("ovf_seen", 12'h004, 32'h8);
    tick();
`ifdef TRDB_STICKY_STATUS_EN
    rd("ovf_sticky", 12'h004, 32'h8);
`else
    rd("ovf_live", 12'h004, 32'h0);
`endif
    tick();
    wr(12'h004, 32'h8);
    rd("ovf_cleared", 12'h004, 32'h0);
    tick();

    // clear_fifo empties the FIFO
    wr(12'h000, 32'h1);
    wr(12'h00C, 32'h1);
    wr(12'h00C, 32'h2);
    rd("fifo_2", 12'h014, 32'h2);
    tick();
    wr(12'h000, 32'h5);
    chk("clear_pulse", 32'(clear_fifo_o), 32'd1);
    tick();
    chk("clear_done", 32'(sw_valid_o), 32'd0);
    rd("clear_empty", 12'h014, 32'h200);
    tick();

    // Reset during a stalled write
    for (int k = 0; k < 4; k++) wr(12'h00C, 32'h10 + 32'(k));
    per_valid_i = 1'b1; per_we_i = 1'b1; per_addr_i = 12'h00C; per_wdata_i = 32'h14;
    #1;
    chk("pre_rst_stall", 32'(per_ready_o), 32'd0);
    rst_ni = 1'b0;
    #1;
    chk("rst_abort_ready", 32'(per_ready_o), 32'd1);
    chk("rst_abort_valid", 32'(sw_valid_o), 32'd0);
    chk("rst_abort_en", 32'(trace_enable_o), 32'd0);
    per_valid_i = 1'b0; per_we_i = 1'b0;
    #1 rst_ni = 1'b1;
    tick();
    rd("post_rst_fifo", 12'h014, 32'h200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
